// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between a crossbar slave port and a register page.
// Carries the five channels; the master modport faces the fabric and the slave modport faces the register file.
interface axi_lite_regfile_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register page: NREG RW control words, NREG RO status words, per-register write pulse.
// Write response one edge after AW+W both latched; read data registered at AR handshake; ready drops while a response is pending.
module axi_lite_regfile #(
    parameter int          NREG    = 16,
    parameter int          REG_AW  = 8,
    parameter int          DW      = 32,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_lite_regfile_if.slave    bus,
    output logic [NREG*DW-1:0]   ctrl,
    output logic [NREG-1:0]      wr_pulse,
    input  logic [NREG*DW-1:0]   status
);
    localparam int         IW          = REG_AW - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [NREG-1:0][DW-1:0] ctrl_q;
    logic                    aw_full;
    logic                    w_full;
    logic [IW-1:0]           aw_idx;
    logic [DW-1:0]           w_data;
    logic [DW/8-1:0]         w_strb;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DW-1:0]           rdata_q;
    logic                    aw_hit;
    logic [IW-1:0]           ar_idx;
    logic [DW-1:0]           rd_val;
    logic [1:0]              rd_resp;
    logic                    awready_int;
    logic                    wready_int;
    logic                    arready_int;
    logic                    unused_bits;

    assign unused_bits = ^{bus.awprot, bus.arprot,
                           bus.awaddr[31:REG_AW], bus.awaddr[1:0],
                           bus.araddr[31:REG_AW], bus.araddr[1:0]};

    // Ready only depends on registered state, never on the incoming valids.
    assign awready_int = !aw_full && !bvalid_q;
    assign wready_int  = !w_full && !bvalid_q;
    assign arready_int = !rvalid_q;

    assign bus.awready = awready_int;
    assign bus.wready  = wready_int;
    assign bus.arready = arready_int;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign ctrl        = ctrl_q;
    assign ar_idx      = bus.araddr[REG_AW-1:2];

    always_comb begin
        aw_hit = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (aw_idx == IW'(k)) aw_hit = 1'b1;
        end
    end

    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NREG; k++) begin
            if (ar_idx == IW'(k)) begin
                rd_val  = ctrl_q[k];
                rd_resp = RESP_OKAY;
            end else if (ar_idx == IW'(k + NREG)) begin
                rd_val  = status[k*DW +: DW];
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q   <= {NREG{RST_VAL}};
            wr_pulse <= '0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            if (bus.awvalid && awready_int) begin
                aw_full <= 1'b1;
                aw_idx  <= bus.awaddr[REG_AW-1:2];
            end
            if (bus.wvalid && wready_int) begin
                w_full <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            // Both halves present: commit one edge later so AW/W ordering does not matter.
            if (aw_full && w_full) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NREG; k++) begin
                    if (aw_idx == IW'(k)) begin
                        wr_pulse[k] <= 1'b1;
                        for (int b = 0; b < DW/8; b++) begin
                            if (w_strb[b]) ctrl_q[k][8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                end
            end
            if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (bus.arvalid && arready_int) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_val;
        end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: write ordering, strobes, decode boundaries, backpressure and reset abort.
module tb_axi_lite_regfile;
    localparam int NREG = 16;

    logic                   aclk;
    logic                   areset;
    logic [NREG*32-1:0]     ctrl;
    logic [NREG-1:0]        wr_pulse;
    logic [NREG*32-1:0]     status;
    logic [NREG-1:0][31:0]  exp_ctrl;
    int                     errors;
    int                     checks;

    axi_lite_regfile_if bus ();

    axi_lite_regfile #(.NREG(NREG), .REG_AW(8), .DW(32), .RST_VAL(32'h0)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .bus      (bus),
        .ctrl     (ctrl),
        .wr_pulse (wr_pulse),
        .status   (status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Same-cycle AW+W; returns at E+1 with the response still pending.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        tick();
    endtask

    task automatic ack_write();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_cleared", bus.bvalid, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        check({tag, "_arready"}, bus.arready, 1'b1);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check({tag, "_rvalid"}, bus.rvalid, 1'b1);
        check({tag, "_rdata"}, bus.rdata, exp_data);
        check({tag, "_rresp"}, bus.rresp, exp_resp);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check({tag, "_rclr"}, bus.rvalid, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_ctrl = '0;
        for (int k = 0; k < NREG; k++) status[k*32 +: 32] = 32'h5000_0000 + k;
        status[63:32] = 32'hCAFEF00D;
        areset = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        tick();
        tick();
        check("rst_ctrl", ctrl, exp_ctrl);
        check("rst_pulse", wr_pulse, 16'h0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        areset = 1'b0;
        tick();

        do_read("rd0", 32'h00, 32'h0, 2'b00);

        // Same-cycle AW and W to word 1.
        bus.awaddr = 32'h04; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("w1_not_yet", bus.bvalid, 1'b0);
        check("w1_aw_busy", bus.awready, 1'b0);
        tick();
        exp_ctrl[1] = 32'hA5A5A5A5;
        check("w1_bvalid", bus.bvalid, 1'b1);
        check("w1_bresp", bus.bresp, 2'b00);
        check("w1_ctrl", ctrl, exp_ctrl);
        check("w1_pulse", wr_pulse, 16'h0002);
        ack_write();
        check("w1_pulse_off", wr_pulse, 16'h0000);
        check("w1_aw_free", bus.awready, 1'b1);
        do_read("rd1", 32'h04, 32'hA5A5A5A5, 2'b00);
        do_read("rd1_lowbits", 32'h06, 32'hA5A5A5A5, 2'b00);

        // W ahead of AW with partial strobes over an all-ones word.
        do_write(32'h08, 32'hFFFFFFFF, 4'hF);
        ack_write();
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("w2_wready_low", bus.wready, 1'b0);
        tick();
        tick();
        check("w2_wait_aw", bus.bvalid, 1'b0);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("w2_not_yet", bus.bvalid, 1'b0);
        tick();
        exp_ctrl[2] = 32'hFF22FF44;
        check("w2_bvalid", bus.bvalid, 1'b1);
        check("w2_ctrl", ctrl, exp_ctrl);
        check("w2_pulse", wr_pulse, 16'h0004);
        ack_write();

        // Zero strobes and last RW word.
        do_write(32'h0C, 32'hDEADBEEF, 4'h0);
        check("w0strb_bresp", bus.bresp, 2'b00);
        check("w0strb_ctrl", ctrl, exp_ctrl);
        check("w0strb_pulse", wr_pulse, 16'h0008);
        ack_write();
        do_write(32'h3C, 32'h0000BEEF, 4'h3);
        exp_ctrl[15] = 32'h0000BEEF;
        check("w15_ctrl", ctrl, exp_ctrl);
        check("w15_pulse", wr_pulse, 16'h8000);
        ack_write();

        // RO and unmapped writes.
        do_write(32'h40, 32'h12345678, 4'hF);
        check("wro_bresp", bus.bresp, 2'b10);
        check("wro_ctrl", ctrl, exp_ctrl);
        check("wro_pulse", wr_pulse, 16'h0);
        ack_write();
        do_write(32'hFC, 32'h12345678, 4'hF);
        check("wun_bresp", bus.bresp, 2'b10);
        check("wun_ctrl", ctrl, exp_ctrl);
        check("wun_pulse", wr_pulse, 16'h0);
        ack_write();
        do_read("rd_unmapped", 32'hFC, 32'h0, 2'b10);
        do_read("rd_first_unmapped", 32'h80, 32'h0, 2'b10);
        do_read("rd_status1", 32'h44, 32'hCAFEF00D, 2'b00);
        do_read("rd_status15", 32'h7C, 32'h5000000F, 2'b00);

        // Write response backpressure.
        do_write(32'h10, 32'h0BADCAFE, 4'hF);
        exp_ctrl[4] = 32'h0BADCAFE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bhold_bvalid", bus.bvalid, 1'b1);
            check("bhold_bresp", bus.bresp, 2'b00);
            check("bhold_readies", {bus.awready, bus.wready}, 2'b00);
        end
        ack_write();

        // Read response backpressure.
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rhold_rvalid", bus.rvalid, 1'b1);
            check("rhold_rdata", bus.rdata, 32'h0BADCAFE);
            check("rhold_arready", bus.arready, 1'b0);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("rhold_clr", bus.rvalid, 1'b0);

        // Read captured on the same edge the write commits must see the old value.
        bus.awaddr = 32'h10; bus.wdata = 32'h600DF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        exp_ctrl[4] = 32'h600DF00D;
        check("race_rdata_old", bus.rdata, 32'h0BADCAFE);
        check("race_ctrl_new", ctrl, exp_ctrl);
        check("race_both_valid", {bus.bvalid, bus.rvalid}, 2'b11);
        bus.rready = 1'b1;
        ack_write();
        check("race_rclr", bus.rvalid, 1'b0);
        bus.rready = 1'b0;

        // Reset with only AW latched aborts the write.
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("abort_aw_latched", {bus.awready, bus.wready}, 2'b01);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        exp_ctrl = '0;
        check("abort_ctrl_reset", ctrl, exp_ctrl);
        bus.wdata = 32'h00000077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick();
        tick();
        check("abort_no_bvalid", bus.bvalid, 1'b0);
        check("abort_ctrl_same", ctrl, exp_ctrl);
        check("abort_aw_free", bus.awready, 1'b1);
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        tick();
        exp_ctrl[5] = 32'h00000077;
        check("post_bvalid", bus.bvalid, 1'b1);
        check("post_ctrl", ctrl, exp_ctrl);
        check("post_pulse", wr_pulse, 16'h0020);
        ack_write();
        do_write(32'h18, 32'h89ABCDEF, 4'hF);
        exp_ctrl[6] = 32'h89ABCDEF;
        check("post2_ctrl", ctrl, exp_ctrl);
        ack_write();
        do_read("post2_rd", 32'h18, 32'h89ABCDEF, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- AXI4-Lite slave register file. Sits directly downstream of one crossbar slave port and terminates its page.
- Provides NREG read/write control registers with per-byte write strobes, plus NREG read-only status words.
- Emits a one-cycle write pulse per register for fabric logic.
- Decodes only the low REG_AW address bits. Page selection is done upstream.

Parameters:
- NREG, 16, number of RW control registers and of RO status words (1..2^(REG_AW-3)).
- REG_AW, 8, address bits decoded (byte address); upper address bits are ignored.
- DW, 32, data width; fixed at 32 (wstrb is 4 bits).
- RST_VAL, 32'h0, reset value of every control register.

Ports:
- aclk, input, 1, clock; all logic on rising edge.
- areset, input, 1, synchronous active-high reset.
- awaddr, input, 32, write address.
- awprot, input, 3, ignored.
- awvalid, input, 1, write address valid.
- awready, output, 1, write address ready.
- wdata, input, 32, write data.
- wstrb, input, 4, byte enables.
- wvalid, input, 1, write data valid.
- wready, output, 1, write data ready.
- bresp, output, 2, 2'b00 OKAY or 2'b10 SLVERR.
- bvalid, output, 1, write response valid.
- bready, input, 1, write response ready.
- araddr, input, 32, read address.
- arprot, input, 3, ignored.
- arvalid, input, 1, read address valid.
- arready, output, 1, read address ready.
- rdata, output, 32, read data.
- rresp, output, 2, read response.
- rvalid, output, 1, read data valid.
- rready, input, 1, read data ready.
- ctrl, output, NREG*32, control register contents; word k at bits [32k+31:32k].
- wr_pulse, output, NREG, one-cycle pulse on the cycle ctrl word k changes due to a bus write.
- status, input, NREG*32, read-only status words; sampled at read.

Behaviour:
- Reset: areset=1 at a clock edge sets the following:
  - ctrl all words to RST_VAL; wr_pulse=0.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - awready=1, wready=1, arready=1.
  - AW/W latches cleared.
- Reset mid-transaction aborts it. No response is issued, and no partial write is applied.
- Decode: word index idx = addr[REG_AW-1:2]; addr[1:0] are ignored.
  - idx < NREG: ctrl[idx], RW.
  - NREG <= idx < 2*NREG: status[idx-NREG], RO.
  - otherwise: unmapped.
- Write path: independent AW and W latches.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - AW and W are accepted in either order or in the same cycle.
  - Edge E is the edge at which the second of the two handshakes completes. At edge E+1:
    - The write is applied, per byte where wstrb[b]=1, if the target is RW.
    - bvalid=1 and bresp is set. Both latches clear.
  - wr_pulse[idx]=1 for the cycle after E+1, only when the target is RW (even if wstrb=0).
  - Write to RO or unmapped: no state change, bresp=SLVERR. wstrb=0 to RW: OKAY, no data change.
  - bvalid is held with bresp stable until bready=1; it clears at that edge.
  - New AW/W are accepted only after bvalid clears. Back-to-back throughput is one write per 3 cycles minimum.
- Read path:
  - arready = !rvalid.
  - On the AR handshake at edge E, rdata/rresp are registered at the same edge E and rvalid=1 after E. The value is the register contents before any write applied at edge E.
  - RW/RO: rresp=OKAY. Unmapped: rdata=32'h0, rresp=SLVERR.
  - rvalid, rdata and rresp are held stable until rready=1; rvalid clears at that edge. Next AR is accepted the following cycle.
- Read and write channels are fully independent and may complete in the same cycle.
- Outputs valid/ready never depend combinationally on valid/ready inputs; all handshake outputs are registered.

Test Plan:
- Reset then read idx 0 (araddr=0x00) -> rvalid one cycle after handshake, rdata=0x00000000, rresp=OKAY.
- AW=0x04 and W=0xA5A5A5A5, wstrb=4'hF in the same cycle -> bvalid next cycle, bresp=OKAY; ctrl[1]=0xA5A5A5A5; wr_pulse[1] single cycle; readback matches.
- W first (0x11223344, wstrb=4'b0101), AW 3 cycles later to 0x08, previous value 0xFFFFFFFF -> ctrl[2]=0xFF22FF44; bvalid only after AW.
- Write to status (0x40 with NREG=16) and to unmapped 0xFC -> bresp=SLVERR, ctrl unchanged, no wr_pulse. Read 0xFC -> rdata=0, rresp=SLVERR. Read 0x44 with status[1]=0xCAFEF00D -> 0xCAFEF00D.
- Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0. Hold rready=0 -> rdata stable, arready=0.
- Assert areset while AW latched but W pending -> after reset no bvalid; ctrl unchanged; subsequent normal write succeeds.
